// File: rtl/cpu_clk_pkg.sv
// ----------------------------------------------------------------------------
// cpu_clk_pkg
// Shared definitions for the CPU clock controller: FSM state encoding and
// the width of the phase and cycle counters.
// ----------------------------------------------------------------------------
package cpu_clk_pkg;

    localparam int CNT_W = 32;

    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

endpackage

// File: rtl/cpu_clk_ctrl_if.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl_if
// Groups the board-facing inputs and the core-facing outputs of the clock
// controller.
//   Run_sw      raw slide switch, 1 = run mode, 0 = step mode
//   Step_btn    raw push button, debounced rising edge requests one step
//   ClkOut      generated clock for the CPU core
//   Tick        one-Clk pulse with every ClkOut rising edge
//   Halted      step mode (or break) with no period in progress
//   CycleCount  ClkOut rising edges since reset
//   Break_cnt / Break_arm  only when CPU_CLK_BREAK_EN is defined
// modport master: drives the raw inputs (board / testbench)
// modport slave : the controller itself
// ----------------------------------------------------------------------------
interface cpu_clk_ctrl_if;
    import cpu_clk_pkg::*;

    logic             Run_sw;
    logic             Step_btn;
    logic             ClkOut;
    logic             Tick;
    logic             Halted;
    logic [CNT_W-1:0] CycleCount;
`ifdef CPU_CLK_BREAK_EN
    logic [CNT_W-1:0] Break_cnt;
    logic [0:0]       Break_arm;

    modport master (
        output Run_sw, Step_btn, Break_cnt, Break_arm,
        input  ClkOut, Tick, Halted, CycleCount
    );

    modport slave (
        input  Run_sw, Step_btn, Break_cnt, Break_arm,
        output ClkOut, Tick, Halted, CycleCount
    );
`else
    modport master (
        output Run_sw, Step_btn,
        input  ClkOut, Tick, Halted, CycleCount
    );

    modport slave (
        input  Run_sw, Step_btn,
        output ClkOut, Tick, Halted, CycleCount
    );
`endif

endinterface

// File: rtl/cpu_clk_ctrl_btn_debounce.sv
// ----------------------------------------------------------------------------
// btn_debounce
// Debounces an already synchronized level. The output only follows the input
// after DB_CYCLES consecutive samples that differ from the current output.
//   Clk    clock
//   Reset  asynchronous active-high reset, output returns to 0
//   din    synchronized raw level
//   dout   debounced level
// ----------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 1_000_000
) (
    input  logic Clk,
    input  logic Reset,
    input  logic din,
    output logic dout
);

    localparam int            CW       = $clog2(DB_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

    logic [CW-1:0] cnt;

    // The counter measures how long din has disagreed with dout; any sample
    // that agrees again restarts the measurement, so bounces never accumulate.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// ----------------------------------------------------------------------------
// cpu_clk_ctrl
// Generates the CPU core clock from the board clock, either free-running with
// period DIV (run mode) or one short period per debounced button press (step
// mode), and counts the generated rising edges for the debug display.
//   Clk    board clock, the only clock in the block
//   Reset  asynchronous active-high reset
//   bus    cpu_clk_ctrl_if.slave: Run_sw, Step_btn in; ClkOut, Tick,
//          Halted, CycleCount out
// Optional feature macro: CPU_CLK_BREAK_EN adds a cycle breakpoint
// (Break_cnt / Break_arm on the interface) that halts run mode after the
// period whose rising edge brings CycleCount to Break_cnt.
// ----------------------------------------------------------------------------
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV       = 50_000_000,
    parameter int DB_CYCLES = 1_000_000,
    parameter int PULSE_W   = 4
) (
    input  logic           Clk,
    input  logic           Reset,
    cpu_clk_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);

    logic             run_s1, run_s;
    logic             btn_s1, btn_s2;
    logic             btn_db, btn_db_q;
    logic             step_req;

    state_t           state, state_next;
    logic [CNT_W-1:0] ph_cnt, ph_cnt_next;
    logic [CNT_W-1:0] hi_last, low_last;
    logic             hi_run, hi_run_next;
    logic             enter_high;
    logic             clk_out, tick;
    logic [CNT_W-1:0] cycle_count;

    // brk_stop: end the current low phase in S_HALT even in run mode.
    // halt_hold: stay in S_HALT even though run_s is high.
    logic             brk_stop;
    logic             halt_hold;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            run_s1   <= 1'b0;
            run_s    <= 1'b0;
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_db_q <= 1'b0;
        end else begin
            run_s1   <= bus.Run_sw;
            run_s    <= run_s1;
            btn_s1   <= bus.Step_btn;
            btn_s2   <= btn_s1;
            btn_db_q <= btn_db;
        end
    end

    btn_debounce #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_debounce (
        .Clk   (Clk),
        .Reset (Reset),
        .din   (btn_s2),
        .dout  (btn_db)
    );

    assign step_req = btn_db & ~btn_db_q;

    // Only S_HALT looks at step_req, so a press during a period is dropped.
    // The high length is fixed by the mode seen at entry (hi_run), while the
    // low length follows the live run_s: dropping Run_sw mid-period finishes
    // the high phase at full length and then ends with a step-length low.
    always_comb begin
        state_next  = state;
        ph_cnt_next = ph_cnt + CNT_W'(1);
        hi_run_next = hi_run;
        enter_high  = 1'b0;
        hi_last     = hi_run ? HALF_LAST : PULSE_LAST;
        low_last    = run_s  ? HALF_LAST : PULSE_LAST;

        case (state)
            S_HALT: begin
                ph_cnt_next = '0;
                if ((run_s && !halt_hold) || step_req) begin
                    state_next  = S_HIGH;
                    enter_high  = 1'b1;
                    hi_run_next = run_s;
                end
            end
            S_HIGH: begin
                if (ph_cnt >= hi_last) begin
                    state_next  = S_LOW;
                    ph_cnt_next = '0;
                end
            end
            S_LOW: begin
                if (ph_cnt >= low_last) begin
                    ph_cnt_next = '0;
                    if (run_s && !brk_stop) begin
                        state_next  = S_HIGH;
                        enter_high  = 1'b1;
                        hi_run_next = 1'b1;
                    end else begin
                        state_next = S_HALT;
                    end
                end
            end
            default: begin
                state_next  = S_HALT;
                ph_cnt_next = '0;
            end
        endcase
    end

    // ClkOut and Tick are registered from the next state so the core sees a
    // glitch-free clock whose rising edge coincides with the Tick pulse.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_HALT;
            ph_cnt      <= '0;
            hi_run      <= 1'b0;
            clk_out     <= 1'b0;
            tick        <= 1'b0;
            cycle_count <= '0;
        end else begin
            state   <= state_next;
            ph_cnt  <= ph_cnt_next;
            hi_run  <= hi_run_next;
            clk_out <= (state_next == S_HIGH);
            tick    <= enter_high;
            if (enter_high) begin
                cycle_count <= cycle_count + CNT_W'(1);
            end
        end
    end

`ifdef CPU_CLK_BREAK_EN
    logic brk_pend;
    logic brk_halt;

    // brk_pend arms on the Tick that brings CycleCount to Break_cnt and makes
    // that period end in S_HALT. brk_halt then holds the halt until Run_sw
    // is seen low (so a 1->0->1 toggle restarts) or a step is requested.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            brk_pend <= 1'b0;
            brk_halt <= 1'b0;
        end else begin
            if (enter_high && bus.Break_arm[0] &&
                ((cycle_count + CNT_W'(1)) == bus.Break_cnt)) begin
                brk_pend <= 1'b1;
            end else if (state == S_LOW && state_next == S_HALT) begin
                brk_pend <= 1'b0;
            end

            if (state == S_LOW && state_next == S_HALT && brk_pend) begin
                brk_halt <= 1'b1;
            end else if (state == S_HALT && (step_req || !run_s)) begin
                brk_halt <= 1'b0;
            end
        end
    end

    assign brk_stop  = brk_pend;
    assign halt_hold = brk_halt;
`else
    assign brk_stop  = 1'b0;
    assign halt_hold = 1'b0;
`endif

    assign bus.ClkOut     = clk_out;
    assign bus.Tick       = tick;
    assign bus.CycleCount = cycle_count;
    assign bus.Halted     = (state == S_HALT) && (!run_s || halt_hold);

endmodule

// File: doc/cpu_clk_ctrl.md
Name: cpu_clk_ctrl

Overview:
- Upstream clock controller for the pipeline CPU core; replaces the plain clock divider in front of it.
- Generates the core's slow clock from the board clock, either free-running (run mode) or one period per debounced push-button press (step mode).
- Also exports a rising-edge count of the generated clock, which is what the display stage shows for single-step debug.

Parameters:
- DIV, 50_000_000, run-mode period of ClkOut in Clk cycles; even, >= 4
- DB_CYCLES, 1_000_000, Clk cycles a button level must stay stable before it is accepted; >= 2
- PULSE_W, 4, step-mode ClkOut high time in Clk cycles; >= 1 and < DIV/2

Ports:
- Clk  in  1  board clock; the only clock in the block
- Reset  in  1  asynchronous, active-high reset
- Run_sw  in  1  raw slide switch; 1 = run mode, 0 = step mode
- Step_btn  in  1  raw push button; a debounced 0->1 edge requests one step
- ClkOut  out  1  registered clock to the CPU core
- Tick  out  1  one-Clk pulse coincident with each ClkOut 0->1 transition
- Halted  out  1  1 while in step mode with no period in progress
- CycleCount  out  32  number of ClkOut rising edges since reset

Behaviour:
- Reset (asynchronous, active-high) forces: ClkOut=0, Tick=0, CycleCount=0, FSM=S_HALT, all counters and synchronizers 0. Halted=1 once the synchronized Run_sw reads 0.
- Input conditioning:
  - Run_sw passes through a 2-flop synchronizer; use the result run_s.
  - Step_btn passes through a 2-flop synchronizer, then btn_debounce. A step request is the debounced 0->1 edge, one Clk pulse wide.
  - Latency from a stable raw press to the step request is 2 + DB_CYCLES + 1 Clk cycles.
- FSM states: S_HALT, S_HIGH, S_LOW. One phase counter ph_cnt, 32 bits.
  - S_HALT: ClkOut=0.
    - If run_s=1, go to S_HIGH.
    - Else, if a step request arrives, go to S_HIGH.
    - Other requests are ignored.
  - Entry to S_HIGH: ClkOut<=1 in the same edge, Tick=1 for that one cycle, CycleCount+1, ph_cnt<=0.
  - S_HIGH: stay for HI cycles, then go to S_LOW with ph_cnt<=0.
    - HI = DIV/2 when run mode was sampled at entry, else PULSE_W.
  - S_LOW: ClkOut=0.
    - Run mode: after DIV/2 cycles, go to S_HIGH.
    - Step mode: after PULSE_W cycles, go to S_HALT.
    - The mode used here is run_s sampled at the S_LOW exit check.
- Run-mode period is exactly DIV Clk cycles, 50% duty.
- A step produces exactly one ClkOut period; minimum step spacing is 2*PULSE_W + 1 cycles.
- A step request while not in S_HALT is dropped; it is not queued.
- Run->step switch mid-period: the current high phase finishes. The low phase uses step length, then the FSM halts. No runt pulse.
- Step->run switch: takes effect at the next S_HALT or S_LOW exit check.
- Halted = (state==S_HALT) && !run_s.
- CycleCount wraps modulo 2^32 without a flag.
- Reset asserted mid-period: ClkOut drops to 0 immediately (asynchronous). No Tick is emitted on reset release.

Optional Feature:
- Macro: CPU_CLK_BREAK_EN
- With the macro defined:
  - Adds input Break_cnt[31:0] and input Break_arm[0:0].
  - When Break_arm=1 and CycleCount becomes equal to Break_cnt on a Tick, the FSM is forced to S_HALT after that period's low phase, even in run mode.
  - The block then stays halted until Run_sw is toggled 1->0->1 or a step request arrives.
  - Halted=1 while break-halted.
- Without the macro: no extra ports, and run mode never self-halts.

Decomposition:
- Shared package cpu_clk_pkg holds:
  - state encoding constants S_HALT=2'd0, S_HIGH=2'd1, S_LOW=2'd2;
  - CNT_W=32.
- Sub-module btn_debounce, parameter DB_CYCLES, ports Clk, Reset, din, dout:
  - saturating stability counter;
  - dout updates only after DB_CYCLES equal consecutive samples.

Test Plan (DIV=8, DB_CYCLES=4, PULSE_W=2, Clk period 10 ns):
- Run free-running: Reset pulse, then Run_sw=1 held -> ClkOut period 80 ns, high 40 ns. CycleCount=5 after the 5th rising edge. Tick is 10 ns wide at each rising edge.
- Single step with bounce: Run_sw=0, Step_btn toggles every 10 ns for 30 ns, then held high 100 ns -> exactly one ClkOut pulse 20 ns wide, CycleCount 0->1, Halted returns to 1.
- Glitch reject and dropped request: Step_btn high for 30 ns only -> no pulse. Second clean press during an active step period -> no extra pulse; CycleCount increments by 1 total.
- Mode switch: Run->step with Run_sw dropped mid-high -> high phase completes at 40 ns, low phase is 20 ns, then S_HALT. No ClkOut pulse shorter than 20 ns.
- Reset mid-high -> ClkOut=0 and CycleCount=0 within the same cycle. After release with Run_sw=1, the first rising edge occurs 3 cycles later (synchronizer plus FSM).
- With CPU_CLK_BREAK_EN: Break_arm=1, Break_cnt=3, run mode -> exactly 3 ClkOut pulses, then Halted=1. A step press gives the 4th pulse.
